mem_arbiter: RTL and testbench

- Two-requester round-robin arbiter in front of the 256x8 synchronous-write / asynchronous-read memory.
- Each requester issues single-cycle read or write commands over a req/gnt handshake.
- The block registers the winning command onto the memory ports and returns read data with a valid strobe.
- A hold limit bounds how long one requester can own the memory while the other waits.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arb_sel.sv | 86 ++++++++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port round-robin memory arbiter.
package mem_arb_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int HOLD_CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arb_sel.sv
// Ownership FSM: round-robin pointer plus hold counter that bounds one side's
// tenure while the other side is waiting.
module mem_arb_sel
  import mem_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_req,
  input  logic b_req,
  input  logic a_acc,
  input  logic b_acc,
  output logic a_gnt,
  output logic b_gnt
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(MAX_HOLD - 1);
  localparam logic [HOLD_CNT_W-1:0] HOLD_ONE  = HOLD_CNT_W'(1);

  state_e                r_state, w_state_nxt;
  logic                  r_prio_b, w_prio_b_nxt;
  logic [HOLD_CNT_W-1:0] r_hold, w_hold_nxt;

  // Next-state, priority and hold-count decision.
  always_comb begin
    w_state_nxt  = r_state;
    w_prio_b_nxt = r_prio_b;
    w_hold_nxt   = r_hold;
    case (r_state)
      IDLE: begin
        if (a_req && b_req) w_state_nxt = r_prio_b ? OWN_B : OWN_A;
        else if (a_req)     w_state_nxt = OWN_A;
        else if (b_req)     w_state_nxt = OWN_B;
        else                w_state_nxt = IDLE;
      end
      OWN_A: begin
        if (!a_req)      w_state_nxt = b_req ? OWN_B : IDLE;
        else if (!b_req) w_hold_nxt = '0;
        else if (a_acc) begin
          // The MAX_HOLD-th accept is also the handover edge, so no cycle is idle.
          if (r_hold == HOLD_LAST) w_state_nxt = OWN_B;
          else                     w_hold_nxt  = r_hold + HOLD_ONE;
        end else begin
          w_hold_nxt = r_hold;
        end
      end
      OWN_B: begin
        if (!b_req)      w_state_nxt = a_req ? OWN_A : IDLE;
        else if (!a_req) w_hold_nxt = '0;
        else if (b_acc) begin
          if (r_hold == HOLD_LAST) w_state_nxt = OWN_A;
          else                     w_hold_nxt  = r_hold + HOLD_ONE;
        end else begin
          w_hold_nxt = r_hold;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_state_nxt != r_state) begin
      w_hold_nxt = '0;
      if (w_state_nxt == OWN_A)      w_prio_b_nxt = 1'b1;
      else if (w_state_nxt == OWN_B) w_prio_b_nxt = 1'b0;
      else                           w_prio_b_nxt = r_prio_b;
    end else begin
      w_prio_b_nxt = r_prio_b;
    end
  end

  // State, pointer and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_prio_b <= 1'b0;
      r_hold   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_prio_b <= w_prio_b_nxt;
      r_hold   <= w_hold_nxt;
    end
  end

  assign a_gnt = (r_state == OWN_A);
  assign b_gnt = (r_state == OWN_B);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin front end for a sync-write / async-read memory.
// Optional MEM_ARB_STATS_EN adds per-requester accepted-command counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int MAX_HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_rvalid,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [ADDR_WIDTH-1:0] mem_rd_add,
  input  logic [DATA_WIDTH-1:0] mem_data_out
`ifdef MEM_ARB_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [15:0]           a_count,
  output logic [15:0]           b_count
`endif
);

  logic                  w_a_acc, w_b_acc, w_acc, w_we, w_wr;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;

  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_wr_addr, r_rd_add;
  logic [DATA_WIDTH-1:0] r_wdata, r_a_rdata, r_b_rdata;
  logic                  r_rpend_a, r_rpend_b, r_a_rvalid, r_b_rvalid;

  assign w_a_acc = a_req && a_gnt;
  assign w_b_acc = b_req && b_gnt;
  assign w_acc   = w_a_acc || w_b_acc;
  assign w_we    = w_a_acc ? a_we    : b_we;
  assign w_addr  = w_a_acc ? a_addr  : b_addr;
  assign w_wdata = w_a_acc ? a_wdata : b_wdata;
  assign w_wr    = w_acc && w_we;

  mem_arb_sel #(.MAX_HOLD(MAX_HOLD)) u_sel (
    .clk   (clk),
    .rst_n (rst_n),
    .a_req (a_req),
    .b_req (b_req),
    .a_acc (w_a_acc),
    .b_acc (w_b_acc),
    .a_gnt (a_gnt),
    .b_gnt (b_gnt)
  );

  // Write port: one-cycle pulse, address/data zeroed when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we      <= 1'b0;
      r_wr_addr <= '0;
      r_wdata   <= '0;
    end else begin
      r_we      <= w_wr;
      r_wr_addr <= w_wr ? w_addr  : '0;
      r_wdata   <= w_wr ? w_wdata : '0;
    end
  end

  // Read address stage then data capture; memory output is sampled one cycle after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_add   <= '0;
      r_rpend_a  <= 1'b0;
      r_rpend_b  <= 1'b0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      if (w_acc && !w_we) r_rd_add <= w_addr;
      r_rpend_a  <= w_a_acc && !a_we;
      r_rpend_b  <= w_b_acc && !b_we;
      r_a_rvalid <= r_rpend_a;
      r_b_rvalid <= r_rpend_b;
      if (r_rpend_a) r_a_rdata <= mem_data_out;
      if (r_rpend_b) r_b_rdata <= mem_data_out;
    end
  end

  assign mem_write_enable = r_we;
  assign mem_wr_addr      = r_wr_addr;
  assign mem_data_in      = r_wdata;
  assign mem_rd_add       = r_rd_add;
  assign a_rdata          = r_a_rdata;
  assign b_rdata          = r_b_rdata;
  assign a_rvalid         = r_a_rvalid;
  assign b_rvalid         = r_b_rvalid;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] r_a_count, r_b_count;

  // Saturating accept counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_count <= 16'h0000;
      r_b_count <= 16'h0000;
    end else if (stats_clr) begin
      r_a_count <= 16'h0000;
      r_b_count <= 16'h0000;
    end else begin
      if (w_a_acc && (r_a_count != 16'hFFFF)) r_a_count <= r_a_count + 16'h0001;
      if (w_b_acc && (r_b_count != 16'hFFFF)) r_b_count <= r_b_count + 16'h0001;
    end
  end

  assign a_count = r_a_count;
  assign b_count = r_b_count;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter with a transaction-level
// reference model; honours MEM_ARB_STATS_EN when defined.
module tb_mem_arbiter;

  localparam int MAX_HOLD = 4;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [7:0] a_addr = 8'h00, a_wdata = 8'h00, b_addr = 8'h00, b_wdata = 8'h00;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid, mem_write_enable;
  logic [7:0] a_rdata, b_rdata, mem_wr_addr, mem_data_in, mem_rd_add, mem_data_out;
`ifdef MEM_ARB_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] a_count, b_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .mem_write_enable(mem_write_enable), .mem_wr_addr(mem_wr_addr),
    .mem_data_in(mem_data_in), .mem_rd_add(mem_rd_add), .mem_data_out(mem_data_out)
`ifdef MEM_ARB_STATS_EN
    , .stats_clr(stats_clr), .a_count(a_count), .b_count(b_count)
`endif
  );

  always #5 clk = ~clk;

  // Attached 256x8 memory: synchronous write, combinational read.
  logic [7:0] env_mem [256];
  logic       mem_clear = 1'b1;
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= 8'h00;
    end else if (mem_write_enable) begin
      env_mem[mem_wr_addr] <= mem_data_in;
    end
  end
  assign mem_data_out = env_mem[mem_rd_add];

  // Reference model state: owner 0=none 1=A 2=B.
  logic [7:0] m_mem [256];
  int         m_own, m_last, m_burst;
  bit         m_acc_a, m_acc_b, m_pw_v, m_rd_a, m_rd_b, m_rv_a, m_rv_b;
  logic [7:0] m_pw_addr, m_pw_data, m_rd_add, m_rd_data, m_a_rdata, m_b_rdata;
  int         m_cnt_a, m_cnt_b;
  cmd_t       qa[$], qb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_last = 2; m_burst = 0;
    m_acc_a = 0; m_acc_b = 0; m_pw_v = 0; m_rd_a = 0; m_rd_b = 0; m_rv_a = 0; m_rv_b = 0;
    m_pw_addr = 8'h00; m_pw_data = 8'h00; m_rd_add = 8'h00; m_rd_data = 8'h00;
    m_a_rdata = 8'h00; m_b_rdata = 8'h00; m_cnt_a = 0; m_cnt_b = 0;
  endtask

  // Advance the model across one rising edge using the inputs presented in that cycle.
  task automatic model_step();
    int         prev;
    logic       we;
    logic [7:0] addr;
    if (m_pw_v) m_mem[m_pw_addr] = m_pw_data;
    m_rv_a = m_rd_a;
    m_rv_b = m_rd_b;
    if (m_rd_a) m_a_rdata = m_rd_data;
    if (m_rd_b) m_b_rdata = m_rd_data;
    m_acc_a = a_req && (m_own == 1);
    m_acc_b = b_req && (m_own == 2);
    we   = m_acc_a ? a_we : b_we;
    addr = m_acc_a ? a_addr : b_addr;
    m_pw_v    = (m_acc_a || m_acc_b) && we;
    m_pw_addr = m_pw_v ? addr : 8'h00;
    m_pw_data = m_pw_v ? (m_acc_a ? a_wdata : b_wdata) : 8'h00;
    m_rd_a = m_acc_a && !we;
    m_rd_b = m_acc_b && !we;
    if (m_rd_a || m_rd_b) begin
      m_rd_data = m_mem[addr];
      m_rd_add  = addr;
    end
`ifdef MEM_ARB_STATS_EN
    if (stats_clr) begin
      m_cnt_a = 0; m_cnt_b = 0;
    end else begin
      if (m_acc_a && m_cnt_a < 65535) m_cnt_a++;
      if (m_acc_b && m_cnt_b < 65535) m_cnt_b++;
    end
`endif
    prev = m_own;
    if (m_own == 0) begin
      if (a_req && b_req) m_own = (m_last == 1) ? 2 : 1;
      else if (a_req)     m_own = 1;
      else if (b_req)     m_own = 2;
    end else begin
      bit mine  = (m_own == 1) ? a_req : b_req;
      bit other = (m_own == 1) ? b_req : a_req;
      if (!mine) m_own = other ? 3 - m_own : 0;
      else if (!other) m_burst = 0;
      else begin
        m_burst++;
        if (m_burst >= MAX_HOLD) m_own = 3 - m_own;
      end
    end
    if (m_own != prev) begin
      m_burst = 0;
      if (m_own != 0) m_last = m_own;
    end
  endtask

  task automatic check_outputs();
    chk("a_gnt", a_gnt, m_own == 1);
    chk("b_gnt", b_gnt, m_own == 2);
    chk("gnt_excl", a_gnt & b_gnt, 1'b0);
    chk("mem_we", mem_write_enable, m_pw_v);
    chk("mem_wr_addr", mem_wr_addr, m_pw_addr);
    chk("mem_data_in", mem_data_in, m_pw_data);
    chk("mem_rd_add", mem_rd_add, m_rd_add);
    chk("a_rvalid", a_rvalid, m_rv_a);
    chk("a_rdata", a_rdata, m_a_rdata);
    chk("b_rvalid", b_rvalid, m_rv_b);
    chk("b_rdata", b_rdata, m_b_rdata);
`ifdef MEM_ARB_STATS_EN
    chk("a_count", a_count, m_cnt_a);
    chk("b_count", b_count, m_cnt_b);
`endif
  endtask

  // One clock: present queue heads (random don't-care when idle), step model, check.
  task automatic cycle();
    a_req = (qa.size() > 0);
    b_req = (qb.size() > 0);
    {a_we, a_addr, a_wdata} = a_req ? qa[0] : 17'($urandom);
    {b_we, b_addr, b_wdata} = b_req ? qb[0] : 17'($urandom);
    @(posedge clk);
    model_step();
    if (m_acc_a) void'(qa.pop_front());
    if (m_acc_b) void'(qb.pop_front());
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drain();
    int budget = 500;
    while ((qa.size() > 0 || qb.size() > 0) && budget > 0) begin
      cycle();
      budget--;
    end
    chk("drain_timeout", budget == 0, 1'b0);
    repeat (3) cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    qa.delete();
    qb.delete();
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.we   = 1'($urandom_range(0, 1));
    c.addr = 8'h40 + 8'($urandom_range(0, 15));
    c.data = 8'($urandom);
    return c;
  endfunction

  initial begin
    int budget;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    model_reset();
    @(negedge clk);
    do_reset();
    mem_clear = 1'b0;

    for (int i = 0; i < 4; i++) qa.push_back('{1'b1, 8'(10 + i), 8'(24 + i)});
    drain();
    for (int i = 0; i < 4; i++) qa.push_back('{1'b0, 8'(10 + i), 8'h00});
    drain();
    chk("a_read_last", a_rdata, 8'd27);

    for (int i = 0; i < 12; i++) begin
      qa.push_back('{1'b0, 8'(10 + (i % 4)), 8'h00});
      qb.push_back('{1'b0, 8'(13 - (i % 4)), 8'h00});
    end
    drain();

    qa.push_back('{1'b1, 8'h20, 8'h5A});
    cycle();
    qb.push_back('{1'b0, 8'h20, 8'h00});
    drain();
    chk("raw_b_rdata", b_rdata, 8'h5A);

    qa.push_back('{1'b0, 8'd10, 8'h00});
    budget = 20;
    do begin
      cycle();
      budget--;
    end while (!m_acc_a && budget > 0);
    chk("rd_accept_timeout", budget == 0, 1'b0);
    do_reset();
    repeat (3) cycle();
    qa.push_back('{1'b0, 8'd11, 8'h00});
    qb.push_back('{1'b0, 8'd12, 8'h00});
    cycle();
    chk("rst_rr_a_first", a_gnt, 1'b1);
    drain();

    for (int i = 0; i < 600; i++) begin
      int pa = ((i / 100) % 2 == 0) ? 80 : 25;
      int pb = ((i / 150) % 2 == 0) ? 70 : 20;
      if (qa.size() < 3 && $urandom_range(0, 99) < pa) qa.push_back(rand_cmd());
      if (qb.size() < 3 && $urandom_range(0, 99) < pb) qb.push_back(rand_cmd());
      cycle();
    end
    drain();

`ifdef MEM_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++) qa.push_back(rand_cmd());
    for (int i = 0; i < 5; i++) qb.push_back(rand_cmd());
    drain();
    chk("stats_a_count", a_count, 16'd3);
    chk("stats_b_count", b_count, 16'd5);
    stats_clr = 1'b1;
    cycle();
    stats_clr = 1'b0;
    chk("stats_a_clr", a_count, 16'd0);
    chk("stats_b_clr", b_count, 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
